// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg
//   Shared definitions for the arb_mux_reg slice: selection mode encoding.
package arb_mux_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SEL   = 2'd0;   // manual select via sel
    localparam mode_t MODE_FIXED = 2'd1;   // lowest-index valid channel wins
    localparam mode_t MODE_RR    = 2'd2;   // round-robin starting at rr_ptr
    localparam mode_t MODE_RSVD  = 2'd3;   // no grant, output drains

endpackage

// File: rtl/rr_grant.sv
// rr_grant
//   Rotating priority encoder: picks the first set req bit at or above base,
//   wrapping modulo NUM_CH. With base=0 it is a plain lowest-index-wins encoder.
// Ports
//   req    in   NUM_CH   request vector
//   base   in   SEL_W    index where the search starts
//   grant  out  NUM_CH   one-hot grant (all zero when no request)
//   idx    out  SEL_W    index of the granted channel
//   any    out  1        a grant exists
module rr_grant #(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  base,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Requests are duplicated side by side; the lower copy is masked below
    // base so the search naturally wraps into the unmasked upper copy.
    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] masked;

    always_comb begin
        req_dbl = {req, req};
        masked  = '0;
        for (int j = 0; j < 2*NUM_CH; j++) begin
            masked[j] = req_dbl[j] & ((j >= NUM_CH) || (j >= int'(base)));
        end
    end

    // Scanning downward and overwriting leaves the lowest set bit as winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int j = 2*NUM_CH-1; j >= 0; j--) begin
            if (masked[j]) begin
                grant              = '0;
                grant[j % NUM_CH]  = 1'b1;
                idx                = SEL_W'(j % NUM_CH);
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// arb_mux_reg
//   NUM_CH-to-1 multiplexer with a registered output stage and valid/ready
//   handshakes on both sides. Grant is chosen by manual select, fixed
//   priority or round-robin; mode 3 grants nothing.
// Ports
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   mode       in   2              0=SEL 1=FIXED 2=RR 3=reserved
//   sel        in   SEL_W          channel used in SEL mode
//   in_data    in   NUM_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NUM_CH         per-channel valid
//   in_ready   out  NUM_CH         per-channel ready (combinational)
//   out_data   out  WIDTH          registered data
//   out_ch     out  SEL_W          source channel of out_data
//   out_valid  out  1              registered valid
//   out_ready  in   1              consumer ready
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    mode_t             mode_m;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  enc_base;
    logic [NUM_CH-1:0] enc_grant;
    logic [SEL_W-1:0]  enc_idx;
    logic              enc_any;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  g_idx;
    logic              g_any;
    logic              accept;
    logic              xfer;

    assign mode_m   = mode_t'(mode);
    assign enc_base = (mode_m == MODE_RR) ? rr_ptr : '0;

    rr_grant #(.NUM_CH(NUM_CH)) u_enc (
        .req   (in_valid),
        .base  (enc_base),
        .grant (enc_grant),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    always_comb begin
        grant = '0;
        g_idx = '0;
        g_any = 1'b0;
        case (mode_m)
            MODE_SEL: begin
                // sel may address a channel that does not exist when NUM_CH
                // is not a power of two; such a select grants nothing.
                if (int'(sel) < NUM_CH) begin
                    if (in_valid[sel]) begin
                        grant[sel] = 1'b1;
                        g_idx      = sel;
                        g_any      = 1'b1;
                    end
                end
            end
            MODE_FIXED, MODE_RR: begin
                grant = enc_grant;
                g_idx = enc_idx;
                g_any = enc_any;
            end
            default: ;
        endcase
    end

    // The output register can take a new beat when empty or being drained.
    assign accept   = ~out_valid | out_ready;
    assign in_ready = grant & {NUM_CH{accept & ~rst}};
    assign xfer     = g_any & accept & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[g_idx*WIDTH +: WIDTH];
            out_ch    <= g_idx;
            if (mode_m == MODE_RR) begin
                rr_ptr <= (g_idx == SEL_W'(NUM_CH-1)) ? '0 : g_idx + SEL_W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
